// File: rtl/detector_jogada.sv
// Player-key conditioning: 2-flop synchroniser, debounce FSM and one-hot validation
// that turns one physical key press into one play strobe. Optional DETECTOR_TIMEOUT_EN.
module detector_jogada #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CW = $clog2(DEBOUNCE_CYCLES + 1)
`ifdef DETECTOR_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 250000000
`endif
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] chaves,
  input  logic       limpa,
  output logic       jogada_feita,
  output logic [3:0] jogada,
  output logic       multipla,
  output logic       db_tem_jogada,
`ifdef DETECTOR_TIMEOUT_EN
  output logic       timeout,
`endif
  output logic [1:0] db_estado
);

  typedef enum logic [1:0] {
    OCIOSO      = 2'd0,
    FILTRA      = 2'd1,
    PRESSIONADO = 2'd2,
    SOLTA       = 2'd3
  } estado_t;

  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  estado_t       state_q, state_d;
  logic [3:0]    sync1_q, sync2_q;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] count_q, count_d;
  logic [3:0]    jogada_q, jogada_d;
  logic          feita_q, feita_d;
  logic          mult_q, mult_d;
  logic [3:0]    s;
  logic          cand_onehot;

  assign s = sync2_q;
  assign cand_onehot = (cand_q != 4'd0) && ((cand_q & (cand_q - 4'd1)) == 4'd0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync1_q  <= 4'd0;
      sync2_q  <= 4'd0;
      state_q  <= OCIOSO;
      cand_q   <= 4'd0;
      count_q  <= '0;
      jogada_q <= 4'd0;
      feita_q  <= 1'b0;
      mult_q   <= 1'b0;
    end else begin
      sync1_q  <= chaves;
      sync2_q  <= sync1_q;
      state_q  <= state_d;
      cand_q   <= cand_d;
      count_q  <= count_d;
      jogada_q <= jogada_d;
      feita_q  <= feita_d;
      mult_q   <= mult_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    count_d  = count_q;
    jogada_d = jogada_q;
    feita_d  = 1'b0;
    mult_d   = 1'b0;
    if (limpa) begin
      // A key still held when the play is cleared must be released before it counts again.
      jogada_d = 4'd0;
      count_d  = '0;
      state_d  = (s == 4'd0) ? OCIOSO : PRESSIONADO;
    end else begin
      case (state_q)
        OCIOSO: begin
          if (s != 4'd0) begin
            cand_d  = s;
            count_d = CNT_ONE;
            state_d = FILTRA;
          end
        end
        FILTRA: begin
          if (s == 4'd0) begin
            state_d = OCIOSO;
          end else if (s != cand_q) begin
            cand_d  = s;
            count_d = CNT_ONE;
          end else if (count_q == CNT_MAX) begin
            state_d = PRESSIONADO;
            if (cand_onehot) begin
              jogada_d = cand_q;
              feita_d  = 1'b1;
            end else begin
              mult_d = 1'b1;
            end
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        PRESSIONADO: begin
          if (s == 4'd0) begin
            count_d = CNT_ONE;
            state_d = SOLTA;
          end
        end
        SOLTA: begin
          if (s != 4'd0) begin
            state_d = PRESSIONADO;
          end else if (count_q == CNT_MAX) begin
            state_d = OCIOSO;
          end else begin
            count_d = count_q + CNT_ONE;
          end
        end
        default: state_d = OCIOSO;
      endcase
    end
  end

  assign jogada_feita  = feita_q;
  assign jogada        = jogada_q;
  assign multipla      = mult_q;
  assign db_tem_jogada = |s;
  assign db_estado     = state_q;

`ifdef DETECTOR_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_done_q, to_done_d;
  logic          timeout_q, timeout_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      to_cnt_q  <= '0;
      to_done_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_done_q <= to_done_d;
      timeout_q <= timeout_d;
    end
  end

  // Runs until a play is accepted or the timeout has fired once; limpa re-arms it.
  always_comb begin
    to_cnt_d  = to_cnt_q;
    to_done_d = to_done_q;
    timeout_d = 1'b0;
    if (limpa) begin
      to_cnt_d  = '0;
      to_done_d = 1'b0;
    end else if (!to_done_q) begin
      if (feita_d || mult_d) begin
        to_done_d = 1'b1;
      end else if (to_cnt_q == TO_MAX) begin
        timeout_d = 1'b1;
        to_done_d = 1'b1;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  assign timeout = timeout_q;
`endif

endmodule

// File: tb/tb_detector_jogada.sv
// Directed bench for detector_jogada with DEBOUNCE_CYCLES=4: table of press scenarios
// plus hand-written reset, limpa and bounce sequences.
module tb_detector_jogada;

  logic       clock;
  logic       reset;
  logic [3:0] chaves;
  logic       limpa;
  logic       jogada_feita;
  logic [3:0] jogada;
  logic       multipla;
  logic       db_tem_jogada;
  logic [1:0] db_estado;
`ifdef DETECTOR_TIMEOUT_EN
  logic       timeout;
`endif

  detector_jogada #(.DEBOUNCE_CYCLES(4)) dut (
    .clock         (clock),
    .reset         (reset),
    .chaves        (chaves),
    .limpa         (limpa),
    .jogada_feita  (jogada_feita),
    .jogada        (jogada),
    .multipla      (multipla),
    .db_tem_jogada (db_tem_jogada),
`ifdef DETECTOR_TIMEOUT_EN
    .timeout       (timeout),
`endif
    .db_estado     (db_estado)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc, feita_cnt, mult_cnt, first_feita, b2b;
  logic prev_feita, prev_mult;

  typedef struct {
    logic [3:0] key;
    int         hold;
    int         exp_feita;
    int         exp_mult;
    logic [3:0] exp_jogada;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic clear_counts();
    cyc = 0;
    feita_cnt = 0;
    mult_cnt = 0;
    first_feita = 0;
  endtask

  // Advance n cycles, sampling outputs on the falling edge.
  task automatic run(input int n);
    repeat (n) begin
      @(negedge clock);
      cyc++;
      if (jogada_feita) begin
        feita_cnt++;
        if (first_feita == 0) first_feita = cyc;
      end
      if (multipla) mult_cnt++;
      if ((jogada_feita && prev_feita) || (multipla && prev_mult)) b2b++;
      prev_feita = jogada_feita;
      prev_mult  = multipla;
    end
  endtask

  initial begin
    vecs[0] = '{4'b0100, 20, 1, 0, 4'b0100};
    vecs[1] = '{4'b0001, 20, 1, 0, 4'b0001};
    vecs[2] = '{4'b1000,  3, 0, 0, 4'b0001};
    vecs[3] = '{4'b0011, 10, 0, 1, 4'b0001};
    vecs[4] = '{4'b0010,  4, 1, 0, 4'b0010};
    vecs[5] = '{4'b1111,  6, 0, 1, 4'b0010};
    vecs[6] = '{4'b1000, 20, 1, 0, 4'b1000};

    b2b = 0;
    prev_feita = 1'b0;
    prev_mult  = 1'b0;
    clear_counts();
    chaves = 4'd0;
    limpa  = 1'b0;
    reset  = 1'b0;
    #1 reset = 1'b1;
    #1;
    check("reset_jogada", 32'(jogada), 0);
    check("reset_feita", 32'(jogada_feita), 0);
    check("reset_multipla", 32'(multipla), 0);
    check("reset_tem_jogada", 32'(db_tem_jogada), 0);
    check("reset_estado", 32'(db_estado), 0);
    run(2);
    reset = 1'b0;

    // Key held, then reset mid-run: outputs clear immediately.
    chaves = 4'b0010;
    run(8);
    check("pre_reset_jogada", 32'(jogada), 32'h2);
    #2 reset = 1'b1;
    #1;
    check("midreset_jogada", 32'(jogada), 0);
    check("midreset_feita", 32'(jogada_feita), 0);
    check("midreset_tem_jogada", 32'(db_tem_jogada), 0);
    check("midreset_estado", 32'(db_estado), 0);
    @(negedge clock);
    reset = 1'b0;
    clear_counts();
    run(10);
    check("latency_first_pulse", 32'(first_feita), 6);
    check("latency_pulse_count", 32'(feita_cnt), 1);
    check("latency_jogada", 32'(jogada), 32'h2);
    chaves = 4'd0;
    run(12);
    check("release_estado", 32'(db_estado), 0);

    // Table-driven press scenarios.
    for (int i = 0; i < 7; i++) begin
      clear_counts();
      chaves = vecs[i].key;
      run(vecs[i].hold);
      check($sformatf("v%0d_tem_jogada", i), 32'(db_tem_jogada), 1);
      chaves = 4'd0;
      run(12);
      check($sformatf("v%0d_feita_count", i), 32'(feita_cnt), 32'(vecs[i].exp_feita));
      check($sformatf("v%0d_mult_count", i), 32'(mult_cnt), 32'(vecs[i].exp_mult));
      check($sformatf("v%0d_jogada", i), 32'(jogada), 32'(vecs[i].exp_jogada));
      check($sformatf("v%0d_estado_idle", i), 32'(db_estado), 0);
    end

    // limpa while the key is still held: no re-detection.
    clear_counts();
    chaves = 4'b0010;
    run(10);
    check("limpa_pre_pulse", 32'(feita_cnt), 1);
    limpa = 1'b1;
    run(1);
    limpa = 1'b0;
    check("limpa_jogada", 32'(jogada), 0);
    check("limpa_estado", 32'(db_estado), 2);
    clear_counts();
    run(10);
    chaves = 4'd0;
    run(2);
    chaves = 4'b0010;
    run(10);
    check("limpa_no_pulse", 32'(feita_cnt), 0);
    check("limpa_short_release_estado", 32'(db_estado), 2);
    check("limpa_jogada_held0", 32'(jogada), 0);
    chaves = 4'd0;
    run(12);
    check("limpa_idle_estado", 32'(db_estado), 0);
    clear_counts();
    chaves = 4'b0010;
    run(10);
    check("limpa_repress_pulse", 32'(feita_cnt), 1);
    check("limpa_repress_jogada", 32'(jogada), 32'h2);
    chaves = 4'd0;
    run(12);

    // Bounce: 2-cycle bursts never qualify; the final stable press gives one pulse.
    clear_counts();
    for (int k = 0; k < 3; k++) begin
      chaves = 4'b0100;
      run(2);
      chaves = 4'd0;
      run(2);
    end
    check("bounce_no_pulse", 32'(feita_cnt + mult_cnt), 0);
    chaves = 4'b0100;
    clear_counts();
    run(12);
    check("bounce_first_pulse", 32'(first_feita), 6);
    check("bounce_pulse_count", 32'(feita_cnt), 1);
    check("bounce_jogada", 32'(jogada), 32'h4);
    chaves = 4'd0;
    run(12);

    check("no_back_to_back_strobes", 32'(b2b), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
